mips_seq_ctrl: RTL

- Multi-cycle FSM controller that sequences the 8-bit x 32 register file and the rest of the MIPS datapath.
- Generates the 3-bit `state` bus consumed by the register file, ALU and PC logic.
- Handles the instruction-fetch handshake and decodes instruction fields into register addresses.
- Gates write-back, and runs the final OUTPUT/HALT phase that displays register 4 on the LEDs.

---
 rtl/mips_seq_ctrl_pkg.sv | 24 ++
 rtl/mips_instr_decode.sv | 35 +++
 rtl/mips_seq_ctrl.sv | 122 ++++++++++++
 3 files changed

// File: rtl/mips_seq_ctrl_pkg.sv
// Shared definitions for the MIPS multi-cycle sequencer: state encodings seen by
// the register file, ALU and PC logic, opcode constants and the LED output register.
package mips_seq_ctrl_pkg;

   typedef enum logic [2:0] {
      STATE_IF     = 3'd0,
      STATE_ID     = 3'd1,
      STATE_RF     = 3'd2,
      STATE_EX     = 3'd3,
      STATE_WB     = 3'd4,
      STATE_OUTPUT = 3'd5,
      STATE_HALT   = 3'd6,
      STATE_IDLE   = 3'd7
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_HALT  = 6'h3F;

   // Register shown on the LEDs during the OUTPUT/HALT phase.
   localparam logic [4:0] OUTPUT_REG = 5'd4;

endpackage

// File: rtl/mips_instr_decode.sv
// Combinational decode of the latched instruction's opcode into write/branch/halt
// class and the write-back destination register.
module mips_instr_decode
   import mips_seq_ctrl_pkg::*;
(
   input  logic [5:0] opcode,
   input  logic [4:0] rt,
   input  logic [4:0] rd,
   output logic       is_write,
   output logic       is_branch,
   output logic       is_halt,
   output logic [4:0] dest
);

   always_comb begin
      is_write  = 1'b0;
      is_branch = 1'b0;
      is_halt   = 1'b0;
      dest      = '0;
      case (opcode)
         OP_RTYPE: begin
            is_write = 1'b1;
            dest     = rd;
         end
         OP_ADDI: begin
            is_write = 1'b1;
            dest     = rt;
         end
         OP_BEQ:  is_branch = 1'b1;
         OP_HALT: is_halt   = 1'b1;
         default: ;
      endcase
   end

endmodule

// File: rtl/mips_seq_ctrl.sv
// Multi-cycle MIPS sequencer: IF/ID/RF/EX/WB loop plus OUTPUT/HALT phase.
// Define CTRL_PERF_EN to build the retired-instruction counter on instr_count.
module mips_seq_ctrl
   import mips_seq_ctrl_pkg::*;
#(
   parameter int unsigned OUT_CYCLES = 4
)(
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic        imem_ready,
   input  logic [31:0] instr,
   input  logic        alu_zero,
   output logic [2:0]  state,
   output logic        imem_req,
   output logic        ir_load,
   output logic [4:0]  rsource,
   output logic [4:0]  rtemp,
   output logic [4:0]  rdestination,
   output logic        result_valid,
   output logic        pc_inc,
   output logic        pc_load,
   output logic        halted,
   output logic [15:0] instr_count
);

   localparam logic [7:0] OUT_LAST = 8'(OUT_CYCLES - 1);

   state_t      cur_state, nxt_state;
   logic [31:0] ir;
   logic        br_flag;
   logic [7:0]  out_cnt;
   logic        dec_write, dec_branch, dec_halt;
   logic [4:0]  dec_dest;
   logic        unused_ir_bits;

   mips_instr_decode u_decode (
      .opcode    (ir[31:26]),
      .rt        (ir[20:16]),
      .rd        (ir[15:11]),
      .is_write  (dec_write),
      .is_branch (dec_branch),
      .is_halt   (dec_halt),
      .dest      (dec_dest)
   );

   assign unused_ir_bits = ^ir[10:0];

   always_ff @(posedge clk) begin
      if (rst) begin
         cur_state <= STATE_IDLE;
         ir        <= '0;
         ir_load   <= 1'b0;
         br_flag   <= 1'b0;
         out_cnt   <= '0;
      end else begin
         cur_state <= nxt_state;
         ir_load   <= (cur_state == STATE_IF) && imem_ready;
         if ((cur_state == STATE_IF) && imem_ready)
            ir <= instr;
         if (cur_state == STATE_EX)
            br_flag <= alu_zero;
         // Held at zero outside OUTPUT so it always starts from 0 on entry.
         if (cur_state == STATE_OUTPUT)
            out_cnt <= out_cnt + 8'd1;
         else
            out_cnt <= '0;
      end
   end

   always_comb begin
      nxt_state    = cur_state;
      imem_req     = 1'b0;
      halted       = 1'b0;
      result_valid = 1'b0;
      pc_inc       = 1'b0;
      pc_load      = 1'b0;
      case (cur_state)
         STATE_IDLE: if (start) nxt_state = STATE_IF;
         STATE_IF: begin
            imem_req = 1'b1;
            if (imem_ready) nxt_state = STATE_ID;
         end
         STATE_ID: nxt_state = dec_halt ? STATE_OUTPUT : STATE_RF;
         STATE_RF: nxt_state = STATE_EX;
         STATE_EX: nxt_state = STATE_WB;
         STATE_WB: begin
            nxt_state    = STATE_IF;
            result_valid = dec_write && (dec_dest != 5'd0);
            pc_load      = dec_branch && br_flag;
            pc_inc       = !dec_halt && !(dec_branch && br_flag);
         end
         STATE_OUTPUT: if (out_cnt == OUT_LAST) nxt_state = STATE_HALT;
         STATE_HALT: begin
            halted = 1'b1;
            if (start) nxt_state = STATE_IF;
         end
         default: nxt_state = STATE_IDLE;
      endcase
   end

   assign state        = cur_state;
   assign rsource      = ir[25:21];
   assign rtemp        = ir[20:16];
   assign rdestination = dec_dest;

`ifdef CTRL_PERF_EN
   logic [15:0] retired_q;

   always_ff @(posedge clk) begin
      if (rst)
         retired_q <= '0;
      else if ((cur_state == STATE_WB) && (nxt_state == STATE_IF))
         retired_q <= retired_q + 16'd1;
   end

   assign instr_count = retired_q;
`else
   assign instr_count = '0;
`endif

endmodule
